// File: rtl/if_prefetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_prefetch_unit_if
// Bundles the control, debug-load and ID-side handshake signals of the
// instruction-fetch stage. Clock and reset are kept as plain module ports.
//
// Signals (direction as seen by the fetch stage, i.e. the slave modport):
//   i_run          in   fetch enable from the debug unit
//   i_dbg_we       in   debug write strobe to instruction memory
//   i_dbg_addr     in   debug byte address (word-aligned)
//   i_dbg_data     in   debug write data
//   i_pcsrc        in   branch taken
//   i_beq_dir      in   branch target
//   i_jump         in   jump taken (wins over i_pcsrc)
//   i_jmp_dir      in   jump target
//   i_ready        in   ID accepts the head entry
//   o_valid        out  head entry valid
//   o_instruction  out  head instruction (0 when !o_valid)
//   o_pc_plus_4    out  PC+4 of head instruction (0 when !o_valid)
//   o_pc           out  current fetch PC
//   o_halted       out  halted with an empty prefetch FIFO
// ---------------------------------------------------------------------------
interface if_prefetch_unit_if #(
  parameter int DATA_W = 32
);
  logic              i_run;
  logic              i_dbg_we;
  logic [DATA_W-1:0] i_dbg_addr;
  logic [DATA_W-1:0] i_dbg_data;
  logic              i_pcsrc;
  logic [DATA_W-1:0] i_beq_dir;
  logic              i_jump;
  logic [DATA_W-1:0] i_jmp_dir;
  logic              i_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_instruction;
  logic [DATA_W-1:0] o_pc_plus_4;
  logic [DATA_W-1:0] o_pc;
  logic              o_halted;

  // Driver side: debug unit, EX/MEM redirect logic and ID stage
  modport master (
    output i_run, i_dbg_we, i_dbg_addr, i_dbg_data,
    output i_pcsrc, i_beq_dir, i_jump, i_jmp_dir, i_ready,
    input  o_valid, o_instruction, o_pc_plus_4, o_pc, o_halted
  );

  // Fetch stage side
  modport slave (
    input  i_run, i_dbg_we, i_dbg_addr, i_dbg_data,
    input  i_pcsrc, i_beq_dir, i_jump, i_jmp_dir, i_ready,
    output o_valid, o_instruction, o_pc_plus_4, o_pc, o_halted
  );
endinterface

// File: rtl/if_prefetch_unit.sv
// ---------------------------------------------------------------------------
// if_prefetch_unit
// Instruction-fetch stage with a prefetch FIFO. Holds the PC and a
// synchronous-read instruction memory loaded through a debug write port,
// and streams {instruction, PC+4} pairs to ID over valid/ready.
// Redirects (jump/branch) flush queued and in-flight fetches; fetch stops
// once a HALT word has been queued.
//
// Ports:
//   i_clk      rising-edge clock
//   i_reset_n  asynchronous active-low reset
//   bus        if_prefetch_unit_if.slave (run, debug load, redirects,
//              ID handshake, PC and halted status); bus DATA_W must match
// ---------------------------------------------------------------------------
module if_prefetch_unit #(
  parameter int                DATA_W     = 32,
  parameter int                IMEM_DEPTH = 256,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_W-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  if_prefetch_unit_if.slave    bus
);

  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] w_pc_nxt;
  logic [DATA_W-1:0] w_pc_plus_4;

  logic [DATA_W-1:0] r_mem [IMEM_DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              r_inflight;
  logic [DATA_W-1:0] r_inflight_pc4;

  logic [DATA_W-1:0] r_fifo_instr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_pc4   [FIFO_DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;

  logic              w_redirect;
  logic [DATA_W-1:0] w_target;
  logic              w_flush;
  logic              w_halt_seen;
  logic              w_room;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic [AW-1:0]     w_pc_idx;
  logic [AW-1:0]     w_dbg_idx;

  // Word index: drop the byte offset, upper bits wrap around the memory.
  assign w_pc_idx    = AW'(r_pc >> 2);
  assign w_dbg_idx   = AW'(bus.i_dbg_addr >> 2);
  assign w_pc_plus_4 = r_pc + PC_STEP;

  assign w_redirect  = bus.i_jump | bus.i_pcsrc;
  assign w_target    = bus.i_jump ? bus.i_jmp_dir : bus.i_beq_dir;
  // In IDLE a redirect only moves the PC; queued work is left alone.
  assign w_flush     = w_redirect && (r_state != ST_IDLE);
  // The word coming back from memory is HALT: stop issuing right away so
  // nothing past the HALT address is ever fetched.
  assign w_halt_seen = r_inflight && (r_rdata == HALT_WORD);
  // The in-flight read owns a FIFO slot, so a push can never overflow.
  assign w_room      = (r_count + CW'(r_inflight)) < CW'(FIFO_DEPTH);
  // No issue in a redirect cycle: the target is issued on the next cycle.
  assign w_issue     = (r_state == ST_FETCH) && !bus.i_dbg_we && w_room &&
                       !w_redirect && !w_halt_seen;
  assign w_push      = r_inflight && !w_flush;
  assign w_valid     = (r_count != {CW{1'b0}});
  assign w_pop       = w_valid && bus.i_ready;

  // Next-state logic for the fetch controller
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_run) w_state_nxt = ST_FETCH;
        else           w_state_nxt = ST_IDLE;
      end
      ST_FETCH: begin
        if (!bus.i_run)                 w_state_nxt = ST_IDLE;
        else if (w_redirect)            w_state_nxt = ST_FETCH;
        else if (w_push && w_halt_seen) w_state_nxt = ST_HALTED;
        else                            w_state_nxt = ST_FETCH;
      end
      ST_HALTED: begin
        if (!bus.i_run)      w_state_nxt = ST_IDLE;
        else if (w_redirect) w_state_nxt = ST_FETCH;
        else                 w_state_nxt = ST_HALTED;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next PC: a redirect wins over sequential advance
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_redirect)   w_pc_nxt = w_target;
    else if (w_issue) w_pc_nxt = w_pc_plus_4;
    else              w_pc_nxt = r_pc;
  end

  // State and PC registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Instruction memory: debug write port and synchronous fetch read
  always_ff @(posedge i_clk) begin
    if (bus.i_dbg_we) r_mem[w_dbg_idx] <= bus.i_dbg_data;
    if (w_issue)      r_rdata <= r_mem[w_pc_idx];
  end

  // In-flight read tracking; a redirect never issues, so it drops the read
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_inflight     <= 1'b0;
      r_inflight_pc4 <= {DATA_W{1'b0}};
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_inflight_pc4 <= w_pc_plus_4;
      else         r_inflight_pc4 <= r_inflight_pc4;
    end
  end

  // Prefetch FIFO storage
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= r_rdata;
      r_fifo_pc4[r_wr_ptr]   <= r_inflight_pc4;
    end
  end

  // Prefetch FIFO pointers and occupancy
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else if (w_flush) begin
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs are taken straight from registers; data is zeroed when empty
  assign bus.o_valid       = w_valid;
  assign bus.o_instruction = w_valid ? r_fifo_instr[r_rd_ptr] : {DATA_W{1'b0}};
  assign bus.o_pc_plus_4   = w_valid ? r_fifo_pc4[r_rd_ptr]   : {DATA_W{1'b0}};
  assign bus.o_pc          = r_pc;
  assign bus.o_halted      = (r_state == ST_HALTED) && !w_valid;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch_unit
// Directed bench for if_prefetch_unit. A queue-based model of the fetch
// stage is stepped on every clock edge; a compare process checks all DUT
// outputs against it on every falling edge, and literal expectations pin
// the model at the points the stimulus targets.
// ---------------------------------------------------------------------------
module tb_if_prefetch_unit;

  localparam int          DW    = 32;
  localparam int          DEPTH = 4;
  localparam int          IMEM  = 256;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  if_prefetch_unit_if #(.DATA_W(DW)) bus ();

  if_prefetch_unit #(
    .DATA_W(DW), .IMEM_DEPTH(IMEM), .FIFO_DEPTH(DEPTH),
    .RESET_PC(32'h0000_0000), .HALT_WORD(HALT)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ---------------- model ----------------
  typedef struct packed { logic [31:0] instr; logic [31:0] pc4; } ent_t;
  logic [31:0] m_mem [IMEM];
  ent_t        m_q[$];
  logic [31:0] m_pc;
  int          m_mode;     // 0 idle, 1 fetching, 2 halted
  bit          m_pend_v;
  ent_t        m_pend;

  function automatic int widx(input logic [31:0] a);
    return int'(a[9:2]);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc     = 32'h0000_0000;
    m_mode   = 0;
    m_pend_v = 1'b0;
  endtask

  // One clock edge worth of fetch-stage rules, using the inputs held over it
  task automatic model_step();
    bit          redirect, flush, issue, halt_arr, arr_v;
    logic [31:0] tgt;
    ent_t        arr;
    redirect = bus.i_jump || bus.i_pcsrc;
    tgt      = bus.i_jump ? bus.i_jmp_dir : bus.i_beq_dir;
    flush    = redirect && (m_mode != 0);
    arr_v    = m_pend_v;
    arr      = m_pend;
    halt_arr = arr_v && (arr.instr == HALT);
    issue    = (m_mode == 1) && !bus.i_dbg_we && !redirect && !halt_arr &&
               ((m_q.size() + int'(m_pend_v)) < DEPTH);
    if (flush) begin
      m_q.delete();
    end else begin
      if (m_q.size() > 0 && bus.i_ready) void'(m_q.pop_front());
      if (arr_v) m_q.push_back(arr);
    end
    m_pend_v = issue;
    if (issue) begin
      m_pend.instr = m_mem[widx(m_pc)];
      m_pend.pc4   = m_pc + 32'd4;
    end
    case (m_mode)
      0:       m_mode = bus.i_run ? 1 : 0;
      1:       m_mode = !bus.i_run ? 0 : redirect ? 1 : halt_arr ? 2 : 1;
      default: m_mode = !bus.i_run ? 0 : redirect ? 1 : 2;
    endcase
    if (redirect)   m_pc = tgt;
    else if (issue) m_pc = m_pc + 32'd4;
    if (bus.i_dbg_we) m_mem[widx(bus.i_dbg_addr)] = bus.i_dbg_data;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: DUT outputs against the model on every falling edge
  initial begin
    logic        ev;
    logic [31:0] ei, ep;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        ev = (m_q.size() != 0);
        ei = ev ? m_q[0].instr : 32'h0;
        ep = ev ? m_q[0].pc4   : 32'h0;
        chk("m_valid",  {31'h0, bus.o_valid}, {31'h0, ev});
        chk("m_instr",  bus.o_instruction, ei);
        chk("m_pc4",    bus.o_pc_plus_4, ep);
        chk("m_pc",     bus.o_pc, m_pc);
        chk("m_halted", {31'h0, bus.o_halted}, {31'h0, (m_mode == 2) && !ev});
      end
    end
  end

  // One clock: inputs held across the edge, model follows, then settle
  task automatic cyc();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic dbg_write(input logic [31:0] a, input logic [31:0] d);
    bus.i_dbg_we   = 1'b1;
    bus.i_dbg_addr = a;
    bus.i_dbg_data = d;
    cyc();
    bus.i_dbg_we   = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic [31:0] ins, input logic [31:0] pc4);
    chk({name, "_valid"}, {31'h0, bus.o_valid}, 32'h1);
    chk({name, "_instr"}, bus.o_instruction, ins);
    chk({name, "_pc4"},   bus.o_pc_plus_4, pc4);
  endtask

  initial begin
    logic [31:0] a;
    bus.i_run = 1'b0;  bus.i_dbg_we = 1'b0; bus.i_dbg_addr = 32'h0; bus.i_dbg_data = 32'h0;
    bus.i_pcsrc = 1'b0; bus.i_beq_dir = 32'h0; bus.i_jump = 1'b0; bus.i_jmp_dir = 32'h0;
    bus.i_ready = 1'b0;
    for (int i = 0; i < IMEM; i++) m_mem[i] = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid",  {31'h0, bus.o_valid}, 32'h0);
    chk("rst_instr",  bus.o_instruction, 32'h0);
    chk("rst_pc",     bus.o_pc, 32'h0);
    chk("rst_halted", {31'h0, bus.o_halted}, 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Load mem[i] = 0x11*(i+1); aliased upper bits and byte offsets must be ignored
    for (int i = 0; i < 40; i++) begin
      a = 32'(i * 4) + ((i % 2 == 1) ? 32'h0000_0400 : 32'h0) + 32'(i % 4);
      dbg_write(a, 32'(32'h11 * (i + 1)));
    end
    dbg_write(32'hFFFF_FFFC, 32'hABCD_0001);   // word 255

    // T1: first valid two edges after run is sampled, then one per cycle
    bus.i_run = 1'b1; bus.i_ready = 1'b1;
    cyc(); chk("t1_lat0", {31'h0, bus.o_valid}, 32'h0);
    cyc(); chk("t1_lat1", {31'h0, bus.o_valid}, 32'h0);
    for (int n = 1; n <= 4; n++) begin
      cyc(); chk_head("t1_head", 32'(32'h11 * n), 32'(4 * n));
    end

    // T2: restart at 0 with ID stalled; FIFO fills and PC stops at 0x10
    bus.i_ready = 1'b0; bus.i_pcsrc = 1'b1; bus.i_beq_dir = 32'h0;
    cyc(); bus.i_pcsrc = 1'b0;
    repeat (10) cyc();
    chk("t2_pc_stop", bus.o_pc, 32'h10);
    chk_head("t2_held", 32'h11, 32'h4);
    bus.i_ready = 1'b1;
    for (int n = 2; n <= 5; n++) begin
      cyc(); chk_head("t2_order", 32'(32'h11 * n), 32'(4 * n));
    end

    // T3: branch to 0x40 while the FIFO is full
    bus.i_ready = 1'b0;
    repeat (6) cyc();
    bus.i_pcsrc = 1'b1; bus.i_beq_dir = 32'h40;
    cyc(); bus.i_pcsrc = 1'b0;
    chk("t3_flushed", {31'h0, bus.o_valid}, 32'h0);
    chk("t3_pc", bus.o_pc, 32'h40);
    cyc(); chk("t3_gap", {31'h0, bus.o_valid}, 32'h0);
    cyc(); chk_head("t3_target", 32'h121, 32'h44);

    // T4: jump and branch together; the jump wins
    bus.i_jump = 1'b1; bus.i_jmp_dir = 32'h80; bus.i_pcsrc = 1'b1; bus.i_beq_dir = 32'h40;
    cyc(); bus.i_jump = 1'b0; bus.i_pcsrc = 1'b0;
    chk("t4_pc", bus.o_pc, 32'h80);
    cyc(); cyc(); chk_head("t4_target", 32'h231, 32'h84);

    // PC+4 wraps modulo 2^32 at the top of the address space
    bus.i_jump = 1'b1; bus.i_jmp_dir = 32'hFFFF_FFFC;
    cyc(); bus.i_jump = 1'b0;
    cyc(); cyc(); chk_head("wrap", 32'hABCD_0001, 32'h0);

    // T5 / T6b: debug write during fetch plants HALT at 0x8, then restart at 0
    bus.i_ready = 1'b1;
    dbg_write(32'h8, HALT);
    bus.i_pcsrc = 1'b1; bus.i_beq_dir = 32'h0;
    cyc(); bus.i_pcsrc = 1'b0;
    chk("t5_flushed", {31'h0, bus.o_valid}, 32'h0);
    cyc(); chk("t5_gap", {31'h0, bus.o_valid}, 32'h0);
    cyc(); chk_head("t5_h0", 32'h11, 32'h4);
    cyc(); chk_head("t5_h1", 32'h22, 32'h8);
    cyc(); chk_head("t5_halt", HALT, 32'hC);
    cyc();
    chk("t5_halted", {31'h0, bus.o_halted}, 32'h1);
    chk("t5_empty",  {31'h0, bus.o_valid}, 32'h0);
    chk("t5_pc",     bus.o_pc, 32'hC);
    repeat (3) cyc();
    chk("t5_still_pc", bus.o_pc, 32'hC);
    bus.i_pcsrc = 1'b1; bus.i_beq_dir = 32'h20;
    cyc(); bus.i_pcsrc = 1'b0;
    chk("t5_resume", {31'h0, bus.o_halted}, 32'h0);
    cyc(); cyc(); chk_head("t5_r0", 32'h99, 32'h24);
    cyc(); chk_head("t5_r1", 32'hAA, 32'h28);

    // T6: asynchronous reset mid-stream
    cyc();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_valid", {31'h0, bus.o_valid}, 32'h0);
    chk("t6_pc",    bus.o_pc, 32'h0);
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(); cyc(); cyc();
    chk_head("t6_restart", 32'h11, 32'h4);
    repeat (4) cyc();
    chk("t6_halted", {31'h0, bus.o_halted}, 32'h1);

    // i_run drop: the FIFO keeps its contents and the PC holds
    bus.i_ready = 1'b0; bus.i_run = 1'b0;
    bus.i_pcsrc = 1'b1; bus.i_beq_dir = 32'h10;
    cyc(); bus.i_pcsrc = 1'b0;
    chk("idle_redirect_pc", bus.o_pc, 32'h10);
    repeat (3) cyc();
    chk("idle_pc_hold", bus.o_pc, 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
